seq_ctl: RTL and testbench

- Parametrised fetch/execute sequencer for the CPU; second generation of the S0–S16 control sequence.
- Drives the system-bus request channel (ROM/RAM/register devices), register-file port strobes and ALU start.
- New over the previous generation: configurable word/operand widths, a variable-latency bus handshake (req/ready) with timeout, and illegal-opcode and halt states.

---
 rtl/seq_ctl_if.sv | 24 ++
 rtl/seq_ctl.sv | 192 +++++++++++++++++++
 tb/tb_seq_ctl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ctl_if.sv
// System-bus request channel between the sequencer (master) and the
// ROM/RAM/register devices (slave).
interface seq_ctl_if #(
    parameter int WORD_W = 16,
    parameter int OPD_W  = 6
);
    logic              bus_req;
    logic [1:0]        bus_dev;
    logic              bus_we;
    logic [OPD_W-1:0]  bus_addr;
    logic [WORD_W-1:0] bus_wdata;
    logic [WORD_W-1:0] bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_req, bus_dev, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_dev, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/seq_ctl.sv
// Fetch/execute sequencer: fetches instructions over the system bus,
// decodes them and drives register-file strobes, ALU start and data
// transfers. Bus transfers use a req/ready handshake with a timeout
// that lands the sequencer in a sticky error state.
module seq_ctl #(
    parameter int WORD_W   = 16,
    parameter int OPC_W    = 4,
    parameter int OPD_W    = (WORD_W - OPC_W) / 2,
    parameter int WAIT_MAX = 7,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              n_reset,
    seq_ctl_if.master         bus,
    output logic [OPD_W-1:0]  reg_raddr,
    input  logic [WORD_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [OPD_W-1:0]  reg_waddr,
    output logic [WORD_W-1:0] reg_wdata,
    output logic              alu_go,
    output logic [OPD_W-1:0]  alu_src,
    output logic [OPD_W-1:0]  alu_dst,
    output logic [OPD_W-1:0]  pc,
    output logic              halted,
    output logic              error
);

    localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

    localparam logic [OPC_W-1:0] OP_NOP   = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_ALU   = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_BR    = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_LDRAM = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_LDROM = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_STRAM = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_HALT  = OPC_W'(15);

    localparam logic [1:0] DEV_IDLE = 2'b00;
    localparam logic [1:0] DEV_ROM  = 2'b01;
    localparam logic [1:0] DEV_RAM  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC_ALU, S_BRANCH, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t            state, state_nx;
    logic [OPD_W-1:0]  pc_q, pc_nx;
    logic [WORD_W-1:0] ir, ir_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [WORD_W-1:0] rdata_hold, rdata_nx;
    logic [WORD_W-1:0] wdata_hold, wdata_nx;

    logic              req;
    logic [1:0]        dev;
    logic              we;
    logic [OPD_W-1:0]  addr;

    logic [OPC_W-1:0]  opc;
    logic [OPD_W-1:0]  op0;
    logic [OPD_W-1:0]  op1;

    assign opc = ir[WORD_W-1 -: OPC_W];
    assign op0 = ir[2*OPD_W-1 -: OPD_W];
    assign op1 = ir[OPD_W-1:0];

    // State and datapath registers; reset returns to a fresh fetch at RESET_PC.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state      <= S_FETCH;
            pc_q       <= OPD_W'(RESET_PC);
            ir         <= '0;
            wait_cnt   <= '0;
            rdata_hold <= '0;
            wdata_hold <= '0;
        end else begin
            state      <= state_nx;
            pc_q       <= pc_nx;
            ir         <= ir_nx;
            wait_cnt   <= wait_nx;
            rdata_hold <= rdata_nx;
            wdata_hold <= wdata_nx;
        end
    end

    // Next-state, datapath updates and per-state strobes, plus the shared bus wait/timeout logic.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc_q;
        ir_nx     = ir;
        wait_nx   = wait_cnt;
        rdata_nx  = rdata_hold;
        wdata_nx  = wdata_hold;
        req       = 1'b0;
        dev       = DEV_IDLE;
        we        = 1'b0;
        addr      = '0;
        reg_raddr = op1;
        reg_we    = 1'b0;
        alu_go    = 1'b0;

        case (state)
            S_FETCH: begin
                req  = 1'b1;
                dev  = DEV_ROM;
                addr = pc_q;
                if (bus.bus_ready) begin
                    ir_nx    = bus.bus_rdata;
                    pc_nx    = pc_q + 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opc)
                    OP_NOP:   state_nx = S_FETCH;
                    OP_ALU:   state_nx = S_EXEC_ALU;
                    OP_BR: begin
                        pc_nx    = op0;
                        state_nx = S_FETCH;
                    end
                    OP_BEQ, OP_BNE:     state_nx = S_BRANCH;
                    OP_LDRAM, OP_LDROM: state_nx = S_MEM;
                    OP_STRAM: begin
                        wdata_nx = reg_rdata;
                        state_nx = S_MEM;
                    end
                    OP_HALT:  state_nx = S_HALT;
                    default:  state_nx = S_ERR;
                endcase
            end
            S_EXEC_ALU: begin
                alu_go   = 1'b1;
                state_nx = S_FETCH;
            end
            S_BRANCH: begin
                reg_raddr = op0;
                if ((opc == OP_BEQ) == (reg_rdata == '0)) begin
                    pc_nx = op1;
                end
                state_nx = S_FETCH;
            end
            S_MEM: begin
                req  = 1'b1;
                addr = op0;
                dev  = (opc == OP_LDROM) ? DEV_ROM : DEV_RAM;
                we   = (opc == OP_STRAM);
                if (bus.bus_ready) begin
                    if (opc == OP_STRAM) begin
                        state_nx = S_FETCH;
                    end else begin
                        rdata_nx = bus.bus_rdata;
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT:  state_nx = S_HALT;
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_ERR;
        endcase

        if (req) begin
            if (bus.bus_ready) begin
                wait_nx = '0;
            end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
                wait_nx  = '0;
                state_nx = S_ERR;
            end else begin
                wait_nx = wait_cnt + 1'b1;
            end
        end
    end

    assign bus.bus_req   = req & n_reset;
    assign bus.bus_dev   = n_reset ? dev : DEV_IDLE;
    assign bus.bus_we    = we & n_reset;
    assign bus.bus_addr  = addr;
    assign bus.bus_wdata = wdata_hold;

    assign reg_waddr = op1;
    assign reg_wdata = rdata_hold;
    assign alu_src   = op0;
    assign alu_dst   = op1;
    assign pc        = pc_q;
    assign halted    = (state == S_HALT);
    assign error     = (state == S_ERR);

endmodule

// File: tb/tb_seq_ctl.sv
// Bench for seq_ctl: acts as ROM/RAM/register-file environment and checks
// the sequencer against an instruction-level model of the CPU.
module tb_seq_ctl;

    localparam int WORD_W   = 16;
    localparam int OPC_W    = 4;
    localparam int OPD_W    = 6;
    localparam int WAIT_MAX = 7;

    logic clock = 1'b0;
    logic n_reset = 1'b0;
    always #5 clock = ~clock;

    seq_ctl_if #(.WORD_W(WORD_W), .OPD_W(OPD_W)) bus ();

    logic [OPD_W-1:0]  reg_raddr, reg_waddr, alu_src, alu_dst, pc;
    logic [WORD_W-1:0] reg_rdata, reg_wdata;
    logic              reg_we, alu_go, halted, error;

    // environment memories (updated from what the DUT actually does)
    logic [WORD_W-1:0] rom  [64];
    logic [WORD_W-1:0] ram  [64];
    logic [WORD_W-1:0] regs [64];
    // instruction-level model state
    logic [WORD_W-1:0] mram  [64];
    logic [WORD_W-1:0] mregs [64];
    logic [5:0]        mpc;

    int vectors     = 0;
    int miscompares = 0;
    int force_delay = -1;

    assign reg_rdata = regs[reg_raddr];

    seq_ctl #(.WORD_W(WORD_W), .OPC_W(OPC_W), .OPD_W(OPD_W), .WAIT_MAX(WAIT_MAX), .RESET_PC(0)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .bus       (bus),
        .reg_raddr (reg_raddr),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .alu_go    (alu_go),
        .alu_src   (alu_src),
        .alu_dst   (alu_dst),
        .pc        (pc),
        .halted    (halted),
        .error     (error)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int o, input int a, input int b);
        return {o[3:0], a[5:0], b[5:0]};
    endfunction

    function automatic int pickDelay();
        if (force_delay >= 0) return force_delay;
        if ($urandom % 2 == 0) return 0;
        return $urandom_range(1, WAIT_MAX - 1);
    endfunction

    task automatic setReg(input int i, input logic [15:0] v);
        regs[i] = v; mregs[i] = v;
    endtask

    task automatic setRam(input int i, input logic [15:0] v);
        ram[i] = v; mram[i] = v;
    endtask

    task automatic loadRandom();
        int r, o;
        for (int i = 0; i < 64; i++) begin
            r = $urandom % 40;
            if (r < 36) o = r % 8;
            else if (r < 38) o = 15;
            else o = 8 + $urandom % 7;
            rom[i] = mk(o, $urandom % 64, $urandom % 64);
            setRam(i, 16'($urandom));
            setReg(i, ($urandom % 2) ? 16'h0 : 16'($urandom));
        end
    endtask

    // one idle clock with ready toggled at random (must be ignored without a request)
    task automatic idleCycle();
        bus.bus_ready = 1'($urandom % 2);
        bus.bus_rdata = 16'($urandom);
        @(negedge clock);
    endtask

    // entered at a negedge where a request is visible; answers after d wait cycles
    task automatic serve(input string tag, input logic [1:0] edev, input bit ewe,
                         input logic [5:0] eaddr, input logic [15:0] ewdata, input int d);
        for (int k = 0; k <= d; k++) begin
            checkOutput({tag, "_req"},  bus.bus_req, 1);
            checkOutput({tag, "_dev"},  bus.bus_dev, edev);
            checkOutput({tag, "_we"},   bus.bus_we, ewe);
            checkOutput({tag, "_addr"}, bus.bus_addr, eaddr);
            if (ewe) checkOutput({tag, "_wdata"}, bus.bus_wdata, ewdata);
            if (k == d) begin
                bus.bus_ready = 1'b1;
                if (bus.bus_dev == 2'b01) bus.bus_rdata = rom[bus.bus_addr];
                else if (!bus.bus_we) bus.bus_rdata = ram[bus.bus_addr];
                else bus.bus_rdata = 16'($urandom);
                if (bus.bus_we && bus.bus_dev == 2'b10) ram[bus.bus_addr] = bus.bus_wdata;
            end else begin
                bus.bus_ready = 1'b0;
                bus.bus_rdata = 16'($urandom);
            end
            @(negedge clock);
        end
        bus.bus_ready = 1'b0;
    endtask

    // executes one instruction at mpc in the model and follows the DUT through it
    task automatic runInstr(output bit stop);
        logic [15:0] w, exp_wd, exp_rd;
        logic [1:0]  exp_dev;
        logic [5:0]  a, b, npc;
        int opc, base, df, dm, term, exp_alu, exp_regw, cycles, alu_cnt, regw_cnt, reqs;
        bit exp_mem, exp_we, mem_done, done;

        w = rom[mpc]; opc = int'(w[15:12]); a = w[11:6]; b = w[5:0];
        npc = mpc + 6'd1; base = 2; term = 0; exp_alu = 0; exp_regw = 0;
        exp_mem = 0; exp_we = 0; exp_dev = 2'b00; exp_wd = '0; exp_rd = '0;
        case (opc)
            0: base = 2;
            1: begin base = 3; exp_alu = 1; end
            2: begin base = 2; npc = a; end
            3: begin base = 3; if (mregs[a] == 0) npc = b; end
            4: begin base = 3; if (mregs[a] != 0) npc = b; end
            5, 6: begin
                base = 4; exp_mem = 1; exp_regw = 1;
                exp_dev = (opc == 5) ? 2'b10 : 2'b01;
                exp_rd = (opc == 5) ? mram[a] : rom[a];
                mregs[b] = exp_rd;
            end
            7: begin
                base = 3; exp_mem = 1; exp_we = 1; exp_dev = 2'b10;
                exp_wd = mregs[b]; mram[a] = exp_wd;
            end
            15: term = 1;
            default: term = 2;
        endcase

        df = pickDelay(); dm = pickDelay();
        serve("fetch", 2'b01, 1'b0, mpc, 16'h0, df);
        cycles = df + 1; alu_cnt = 0; regw_cnt = 0; mem_done = 0; done = 0;
        for (int t = 0; t < 40 && !done; t++) begin
            if (halted || error) begin
                done = 1;
            end else if (bus.bus_req) begin
                if (exp_mem && !mem_done) begin
                    serve("mem", exp_dev, exp_we, a, exp_wd, dm);
                    cycles += dm + 1; mem_done = 1;
                end else begin
                    done = 1;
                end
            end else begin
                if (alu_go) begin
                    alu_cnt++;
                    checkOutput("alu_src", alu_src, a);
                    checkOutput("alu_dst", alu_dst, b);
                end
                if (reg_we) begin
                    regw_cnt++;
                    checkOutput("reg_waddr", reg_waddr, b);
                    checkOutput("reg_wdata", reg_wdata, exp_rd);
                    regs[reg_waddr] = reg_wdata;
                end
                cycles++;
                idleCycle();
            end
        end
        checkOutput("instr_done", done, 1);
        checkOutput("cycles", cycles, base + df + (exp_mem ? dm : 0));
        checkOutput("alu_pulses", alu_cnt, exp_alu);
        checkOutput("reg_writes", regw_cnt, exp_regw);
        checkOutput("mem_xfer", mem_done, exp_mem);
        checkOutput("halted", halted, term == 1);
        checkOutput("error", error, term == 2);
        if (term == 0) begin
            checkOutput("next_pc", pc, npc);
        end else begin
            reqs = 0;
            for (int k = 0; k < 20; k++) begin
                if (bus.bus_req) reqs++;
                idleCycle();
            end
            checkOutput("term_no_req", reqs, 0);
            checkOutput("term_sticky", (term == 1) ? halted : error, 1);
        end
        mpc  = npc;
        stop = (term != 0) || !done;
    endtask

    // runs up to n instructions then compares environment against model memories
    task automatic applyStimulus(input int n);
        bit stop;
        int dram, dreg;
        stop = 0;
        for (int i = 0; i < n && !stop; i++) runInstr(stop);
        dram = 0; dreg = 0;
        for (int i = 0; i < 64; i++) begin
            if (ram[i] !== mram[i]) dram++;
            if (regs[i] !== mregs[i]) dreg++;
        end
        checkOutput("ram_state", dram, 0);
        checkOutput("reg_state", dreg, 0);
    endtask

    // entered at a negedge; leaves at negedge+1 with the first fetch visible
    task automatic applyReset();
        n_reset = 1'b0;
        bus.bus_ready = 1'b0;
        #1;
        checkOutput("rst_req", bus.bus_req, 0);
        checkOutput("rst_dev", bus.bus_dev, 0);
        @(negedge clock);
        checkOutput("rst_pc", pc, 0);
        n_reset = 1'b1;
        mpc = 6'd0;
        #1;
    endtask

    initial begin
        bus.bus_ready = 1'b0;
        bus.bus_rdata = '0;
        force_delay = -1;

        // reset state, then reset pulsed mid-fetch with ready stuck low
        loadRandom();
        rom[0] = mk(5, 5, 3);
        rom[1] = mk(7, 6, 3);
        setRam(5, 16'hBEEF);
        repeat (2) @(negedge clock);
        checkOutput("init_req", bus.bus_req, 0);
        checkOutput("init_dev", bus.bus_dev, 0);
        checkOutput("init_we", bus.bus_we, 0);
        checkOutput("init_reg_we", reg_we, 0);
        checkOutput("init_alu_go", alu_go, 0);
        checkOutput("init_halted", halted, 0);
        checkOutput("init_error", error, 0);
        checkOutput("init_pc", pc, 0);
        n_reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stuck_req", bus.bus_req, 1);
            @(negedge clock);
        end
        applyReset();
        checkOutput("rel_req", bus.bus_req, 1);
        checkOutput("rel_addr", bus.bus_addr, 0);
        checkOutput("rel_error", error, 0);

        // load then store through a register, zero-wait memory
        force_delay = 0;
        applyStimulus(2);
        checkOutput("st_ram6", ram[6], 16'hBEEF);
        checkOutput("ld_reg3", regs[3], 16'hBEEF);

        // BEQ / BNE taken and not taken
        for (int o = 3; o <= 4; o++) begin
            for (int r = 0; r < 2; r++) begin
                rom[0] = mk(o, 2, 6'h20);
                setReg(2, 16'(r));
                applyReset();
                applyStimulus(1);
            end
        end

        // fetch waits of 3 and WAIT_MAX-1 complete without error
        force_delay = 3;
        rom[0] = mk(0, 0, 0);
        applyReset();
        applyStimulus(1);
        force_delay = WAIT_MAX - 1;
        applyReset();
        applyStimulus(1);

        // WAIT_MAX unacknowledged cycles -> error, no further requests
        applyReset();
        for (int k = 0; k < WAIT_MAX; k++) begin
            checkOutput("to_req", bus.bus_req, 1);
            checkOutput("to_err_early", error, 0);
            bus.bus_ready = 1'b0;
            @(negedge clock);
        end
        checkOutput("to_error", error, 1);
        checkOutput("to_req_drop", bus.bus_req, 0);
        begin
            int reqs = 0;
            for (int k = 0; k < 10; k++) begin
                if (bus.bus_req) reqs++;
                idleCycle();
            end
            checkOutput("to_no_req", reqs, 0);
        end

        // pc wrap, illegal opcode, halt
        force_delay = 0;
        rom[0] = mk(2, 63, 0);
        rom[63] = mk(0, 0, 0);
        applyReset();
        applyStimulus(3);
        rom[0] = mk(9, 1, 2);
        applyReset();
        applyStimulus(1);
        rom[0] = mk(15, 0, 0);
        applyReset();
        applyStimulus(1);

        // random programs with random bus latency
        force_delay = -1;
        for (int s = 0; s < 6; s++) begin
            loadRandom();
            applyReset();
            applyStimulus(60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
